async_pulse_synch: RTL and testbench

// - Brings a single-bit asynchronous input into the clk domain through an N-flop

---
 rtl/async_pulse_synch_pkg.sv | 15 +
 rtl/async_pulse_synch_if.sv | 16 +
 rtl/async_pulse_synch_ff_chain.sv | 38 +++
 rtl/async_pulse_synch.sv | 44 ++++
 tb/tb_async_pulse_synch.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/async_pulse_synch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : synch_pkg
// Brief    : Shared constants for single-bit CDC synchronizer blocks.
// Revision : 1.0 - initial release
// ============================================================================
package synch_pkg;

  localparam int   SYNC_STAGES_DEFAULT = 2;
  localparam int   SYNC_STAGES_MIN     = 2;
  localparam int   SYNC_STAGES_MAX     = 4;
  localparam logic SYNC_RST_VAL        = 1'b0;

endpackage
`default_nettype wire

// File: rtl/async_pulse_synch_if.sv
`default_nettype none
// ============================================================================
// Module   : async_pulse_synch_if
// Brief    : Asynchronous level in, synchronized one-cycle pulse out.
// Revision : 1.0 - initial release
// ============================================================================
interface async_pulse_synch_if;

  logic asynch_in;
  logic asynch_out;

  modport master (output asynch_in, input asynch_out);
  modport slave  (input asynch_in, output asynch_out);

endinterface
`default_nettype wire

// File: rtl/async_pulse_synch_ff_chain.sv
`default_nettype none
// ============================================================================
// Module   : synch_ff_chain
// Brief    : Plain N-flop synchronizer chain, reusable by any single-bit CDC.
// Revision : 1.0 - initial release
// ============================================================================
module synch_ff_chain
  import synch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d,
  output logic      q
);

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
      $error("synch_ff_chain: SYNC_STAGES=%0d outside legal range", SYNC_STAGES);
    end
  endgenerate

  // Placement tools keep these flops adjacent to maximise metastability settling time.
  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{SYNC_RST_VAL}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
    end
  end

  assign q = r_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire

// File: rtl/async_pulse_synch.sv
`default_nettype none
// ============================================================================
// Module   : async_pulse_synch
// Brief    : Synchronizes an async level and emits one clk pulse per rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module async_pulse_synch
  import synch_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  async_pulse_synch_if.slave sif
);

  logic w_sync;
  logic r_prev;
  logic r_pulse;

  synch_ff_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (sif.asynch_in),
    .q     (w_sync)
  );

  // History clears with reset, so the chain output must be seen low before a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= SYNC_RST_VAL;
      r_pulse <= SYNC_RST_VAL;
    end else begin
      r_prev  <= w_sync;
      r_pulse <= w_sync & ~r_prev;
    end
  end

  assign sif.asynch_out = r_pulse;

endmodule
`default_nettype wire

// File: tb/tb_async_pulse_synch.sv
`default_nettype none
// ============================================================================
// Module   : tb_async_pulse_synch
// Brief    : Randomized self-checking bench for async_pulse_synch (2 and 3 stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_async_pulse_synch;

  localparam int N_TRAIN = 2000;
  localparam int HIST    = 8;

  logic clk;
  logic rst_n;

  async_pulse_synch_if if2 ();
  async_pulse_synch_if if3 ();

  async_pulse_synch #(.SYNC_STAGES(2)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if2.slave)
  );

  async_pulse_synch #(.SYNC_STAGES(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .sif   (if3.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cnt2   = 0;
  int cnt3   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: input samples taken at each posedge since reset release.
  // A pulse is due N posedges after a sample that is high following one that is low.
  bit   hist[$];
  logic exp2 = 1'b0;
  logic exp3 = 1'b0;

  function automatic void clear_hist();
    hist = {};
    for (int i = 0; i < HIST; i++) hist.push_back(1'b0);
  endfunction

  function automatic logic edge_due(input int n);
    return hist[hist.size()-n] & ~hist[hist.size()-n-1];
  endfunction

  always @(negedge rst_n) begin
    clear_hist();
    exp2 = 1'b0;
    exp3 = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      clear_hist();
      exp2 = 1'b0;
      exp3 = 1'b0;
    end else begin
      exp2 = edge_due(2);
      exp3 = edge_due(3);
      hist.push_back(if2.asynch_in);
      if (hist.size() > HIST) void'(hist.pop_front());
    end
  end

  logic last2 = 1'b0;
  logic last3 = 1'b0;

  always @(negedge clk) begin
    check("out_s2",   32'(if2.asynch_out), 32'(exp2));
    check("out_s3",   32'(if3.asynch_out), 32'(exp3));
    check("width_s2", 32'(if2.asynch_out & last2), 32'd0);
    check("width_s3", 32'(if3.asynch_out & last3), 32'd0);
    last2 = if2.asynch_out;
    last3 = if3.asynch_out;
    if (if2.asynch_out === 1'b1) cnt2++;
    if (if3.asynch_out === 1'b1) cnt3++;
  end

  task automatic set_in(input logic v);
    if2.asynch_in = v;
    if3.asynch_in = v;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clr_cnt();
    cnt2 = 0;
    cnt3 = 0;
  endtask

  task automatic check_cnt(input string tag, input int exp);
    check({tag, "_s2"}, 32'(cnt2), 32'(exp));
    check({tag, "_s3"}, 32'(cnt3), 32'(exp));
  endtask

  initial begin
    rst_n = 1'b1;
    set_in(1'b0);
    #1 rst_n = 1'b0;

    // Reset held while the input toggles
    repeat (8) begin
      @(negedge clk);
      #1 set_in(1'($urandom_range(0, 1)));
    end
    check("rst_out_s2", 32'(if2.asynch_out), 32'd0);
    check("rst_out_s3", 32'(if3.asynch_out), 32'd0);
    set_in(1'b0);
    rst_n = 1'b1;
    clr_cnt();
    cyc(4);
    check_cnt("post_rst", 0);

    // Single one-period pulse
    clr_cnt();
    set_in(1'b1);
    cyc(1);
    set_in(1'b0);
    cyc(6);
    check_cnt("single", 1);

    // Pulse train
    clr_cnt();
    for (int i = 0; i < N_TRAIN; i++) begin
      set_in(1'b0);
      cyc(5);
      set_in(1'b1);
      cyc(1);
    end
    set_in(1'b0);
    cyc(6);
    check_cnt("train", N_TRAIN);

    // Held high, then a second assertion
    clr_cnt();
    set_in(1'b1);
    cyc(50);
    set_in(1'b0);
    cyc(6);
    check_cnt("held", 1);
    set_in(1'b1);
    cyc(3);
    set_in(1'b0);
    cyc(6);
    check_cnt("rearm", 2);

    // Glitch between posedges
    clr_cnt();
    set_in(1'b1);
    #3 set_in(1'b0);
    cyc(6);
    check_cnt("glitch", 0);

    // Reset one cycle after capture
    clr_cnt();
    set_in(1'b1);
    cyc(1);
    cyc(1);
    rst_n = 1'b0;
    set_in(1'b0);
    #1;
    check("midrst_s2", 32'(if2.asynch_out), 32'd0);
    check("midrst_s3", 32'(if3.asynch_out), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(6);
    check_cnt("midrst", 0);

    // Randomized phase: levels with random hold, glitches and resets
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        set_in(1'b0);
        cyc(1);
        set_in(1'b1);
        #3 set_in(1'b0);
        cyc(1);
      end else if (r < 5) begin
        rst_n = 1'b0;
        set_in(1'($urandom_range(0, 1)));
        #1;
        check("rnd_rst_s2", 32'(if2.asynch_out), 32'd0);
        check("rnd_rst_s3", 32'(if3.asynch_out), 32'd0);
        cyc(int'($urandom_range(1, 3)));
        set_in(1'b0);
        rst_n = 1'b1;
        cyc(1);
      end else begin
        set_in(1'($urandom_range(0, 1)));
        cyc(int'($urandom_range(1, 4)));
      end
    end
    set_in(1'b0);
    cyc(6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
